// File: rtl/nvdla_ctrl_reg_router_if.sv
`default_nettype none
// ============================================================================
// Module      : nvdla_ctrl_reg_router_if
// Description : AXI-lite bundle (AW/W/B/AR/R) with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface nvdla_ctrl_reg_router_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface
`default_nettype wire

// File: rtl/nvdla_ctrl_reg_router.sv
`default_nettype none
// ============================================================================
// Module      : nvdla_ctrl_reg_router
// Description : AXI-lite control front end. Low window hits local action
//               registers, everything above is forwarded to the NVDLA CSB
//               port with the window offset removed. One access in flight.
//               Also turns the NVDLA interrupt level into the SNAP
//               raise/hold/ack interrupt handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module nvdla_ctrl_reg_router #(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter logic [31:0] LOCAL_SPAN     = 32'h100,
  parameter int          INT_BITS       = 3,
  parameter int          CONTEXT_BITS   = 8,
  parameter logic [31:0] ACTION_TYPE    = 32'h00000006,
  parameter logic [31:0] ACTION_VERSION = 32'h00000000
) (
  input  wire logic                    ap_clk,
  input  wire logic                    ap_rst,
  nvdla_ctrl_reg_router_if.slave       s_axi,
  nvdla_ctrl_reg_router_if.master      m_axi,
  input  wire logic                    nvdla_intr,
  output logic                         interrupt,
  output logic [INT_BITS-2:0]          interrupt_src,
  output logic [CONTEXT_BITS-1:0]      interrupt_ctx,
  input  wire logic                    interrupt_ack
);

  localparam logic [ADDR_W-1:0] c_LOCAL_SPAN = ADDR_W'(LOCAL_SPAN);

  typedef enum logic [3:0] {
    IDLE, L_WR, L_RD, F_WR, F_WR_B, F_RD, F_RD_R, S_B, S_R
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [ADDR_W-1:0]        r_addr;
  logic [DATA_W-1:0]        r_wdata;
  logic [DATA_W/8-1:0]      r_wstrb;
  logic [DATA_W-1:0]        r_rdata;
  logic [1:0]               r_resp;
  logic                     r_aw_done, r_w_done;
  logic                     r_int_en, r_pending;
  logic [CONTEXT_BITS-1:0]  r_ctx;
  logic                     r_intr_s, r_intr_d;

  logic                     w_wr_acc, w_rd_acc;
  logic                     w_s_awready, w_s_arready, w_s_bvalid, w_s_rvalid;
  logic                     w_m_awvalid, w_m_wvalid, w_m_bready, w_m_arvalid, w_m_rready;
  logic [DATA_W-1:0]        w_local_rdata;
  logic                     w_intr_edge;

  // State register; async reset drops any transaction in flight
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake decode; readies are also held low during reset
  always_comb begin
    w_state_nxt = r_state;
    w_wr_acc    = 1'b0;
    w_rd_acc    = 1'b0;
    w_s_awready = 1'b0;
    w_s_arready = 1'b0;
    w_s_bvalid  = 1'b0;
    w_s_rvalid  = 1'b0;
    w_m_awvalid = 1'b0;
    w_m_wvalid  = 1'b0;
    w_m_bready  = 1'b0;
    w_m_arvalid = 1'b0;
    w_m_rready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!ap_rst && s_axi.awvalid && s_axi.wvalid) begin
          // A complete write pair beats a read in the same cycle
          w_s_awready = 1'b1;
          w_wr_acc    = 1'b1;
          w_state_nxt = (s_axi.awaddr < c_LOCAL_SPAN) ? L_WR : F_WR;
        end else if (!ap_rst && s_axi.arvalid) begin
          w_s_arready = 1'b1;
          w_rd_acc    = 1'b1;
          w_state_nxt = (s_axi.araddr < c_LOCAL_SPAN) ? L_RD : F_RD;
        end
      end
      L_WR: w_state_nxt = S_B;
      L_RD: w_state_nxt = S_R;
      F_WR: begin
        w_m_awvalid = !r_aw_done;
        w_m_wvalid  = !r_w_done;
        if ((r_aw_done || m_axi.awready) && (r_w_done || m_axi.wready))
          w_state_nxt = F_WR_B;
      end
      F_WR_B: begin
        w_m_bready = 1'b1;
        if (m_axi.bvalid) w_state_nxt = S_B;
      end
      F_RD: begin
        w_m_arvalid = 1'b1;
        if (m_axi.arready) w_state_nxt = F_RD_R;
      end
      F_RD_R: begin
        w_m_rready = 1'b1;
        if (m_axi.rvalid) w_state_nxt = S_R;
      end
      S_B: begin
        w_s_bvalid = 1'b1;
        if (s_axi.bready) w_state_nxt = IDLE;
      end
      S_R: begin
        w_s_rvalid = 1'b1;
        if (s_axi.rready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Local register read mux; unmapped offsets read zero
  always_comb begin
    w_local_rdata = '0;
    if (r_addr == ADDR_W'(32'h00))      w_local_rdata = DATA_W'({r_int_en, r_pending});
    else if (r_addr == ADDR_W'(32'h04)) w_local_rdata = DATA_W'(r_int_en);
    else if (r_addr == ADDR_W'(32'h08)) w_local_rdata = DATA_W'(r_ctx);
    else if (r_addr == ADDR_W'(32'h10)) w_local_rdata = DATA_W'(ACTION_TYPE);
    else if (r_addr == ADDR_W'(32'h14)) w_local_rdata = DATA_W'(ACTION_VERSION);
  end

  // Request latch, downstream handshake tracking, local writes, response capture
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_resp    <= 2'b00;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_int_en  <= 1'b0;
      r_ctx     <= '0;
    end else begin
      if (w_wr_acc) begin
        r_addr    <= s_axi.awaddr;
        r_wdata   <= s_axi.wdata;
        r_wstrb   <= s_axi.wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_rd_acc) r_addr <= s_axi.araddr;
      if (w_m_awvalid && m_axi.awready) r_aw_done <= 1'b1;
      if (w_m_wvalid && m_axi.wready)   r_w_done  <= 1'b1;
      if (r_state == L_WR) begin
        r_resp <= 2'b00;
        if (r_addr == ADDR_W'(32'h04)) r_int_en <= r_wdata[0];
        if (r_addr == ADDR_W'(32'h08)) r_ctx    <= r_wdata[CONTEXT_BITS-1:0];
      end
      if (r_state == L_RD) begin
        r_resp  <= 2'b00;
        r_rdata <= w_local_rdata;
      end
      if (r_state == F_WR_B && m_axi.bvalid) r_resp <= m_axi.bresp;
      if (r_state == F_RD_R && m_axi.rvalid) begin
        r_rdata <= m_axi.rdata;
        r_resp  <= m_axi.rresp;
      end
    end
  end

  // Interrupt: registered edge detect; a fresh edge outranks a same-cycle ack
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_intr_s  <= 1'b0;
      r_intr_d  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_intr_s <= nvdla_intr;
      r_intr_d <= r_intr_s;
      if (w_intr_edge && r_int_en) r_pending <= 1'b1;
      else if (interrupt_ack)      r_pending <= 1'b0;
    end
  end

  assign w_intr_edge   = r_intr_s & ~r_intr_d;
  assign interrupt     = r_pending;
  assign interrupt_ctx = r_ctx;
  assign interrupt_src = '0;

  assign s_axi.awready = w_s_awready;
  assign s_axi.wready  = w_s_awready;
  assign s_axi.arready = w_s_arready;
  assign s_axi.bvalid  = w_s_bvalid;
  assign s_axi.bresp   = r_resp;
  assign s_axi.rvalid  = w_s_rvalid;
  assign s_axi.rresp   = r_resp;
  assign s_axi.rdata   = r_rdata;

  // Downstream payloads are only driven while their request is outstanding
  assign m_axi.awvalid = w_m_awvalid;
  assign m_axi.awaddr  = (r_state == F_WR) ? (r_addr - c_LOCAL_SPAN) : '0;
  assign m_axi.wvalid  = w_m_wvalid;
  assign m_axi.wdata   = (r_state == F_WR) ? r_wdata : '0;
  assign m_axi.wstrb   = (r_state == F_WR) ? r_wstrb : '0;
  assign m_axi.bready  = w_m_bready;
  assign m_axi.arvalid = w_m_arvalid;
  assign m_axi.araddr  = (r_state == F_RD) ? (r_addr - c_LOCAL_SPAN) : '0;
  assign m_axi.rready  = w_m_rready;

endmodule
`default_nettype wire

// File: tb/tb_nvdla_ctrl_reg_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_nvdla_ctrl_reg_router
// Description : Directed self-checking bench for nvdla_ctrl_reg_router.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nvdla_ctrl_reg_router;

  logic       ap_clk = 1'b0;
  logic       ap_rst = 1'b1;
  logic       nvdla_intr = 1'b0;
  logic       interrupt_ack = 1'b0;
  logic       interrupt;
  logic [1:0] interrupt_src;
  logic [7:0] interrupt_ctx;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic [1:0]  rsp;
  int          lat;

  nvdla_ctrl_reg_router_if #(.ADDR_W(32), .DATA_W(32)) s_if ();
  nvdla_ctrl_reg_router_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

  nvdla_ctrl_reg_router dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .s_axi         (s_if),
    .m_axi         (m_if),
    .nvdla_intr    (nvdla_intr),
    .interrupt     (interrupt),
    .interrupt_src (interrupt_src),
    .interrupt_ctx (interrupt_ctx),
    .interrupt_ack (interrupt_ack)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [31:0] a, input logic [31:0] d,
                            output logic [1:0] resp, output int l);
    int n;
    @(negedge ap_clk);
    s_if.awaddr = a; s_if.awvalid = 1'b1;
    s_if.wdata = d;  s_if.wstrb = 4'hF; s_if.wvalid = 1'b1;
    #1; n = 0;
    while (!s_if.awready && n < 20) begin @(negedge ap_clk); #1; n++; end
    @(negedge ap_clk);
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    l = 1;
    while (!s_if.bvalid && l < 20) begin @(negedge ap_clk); l++; end
    resp = s_if.bresp;
    s_if.bready = 1'b1;
    @(negedge ap_clk);
    s_if.bready = 1'b0;
  endtask

  task automatic host_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int l);
    int n;
    @(negedge ap_clk);
    s_if.araddr = a; s_if.arvalid = 1'b1;
    #1; n = 0;
    while (!s_if.arready && n < 20) begin @(negedge ap_clk); #1; n++; end
    @(negedge ap_clk);
    s_if.arvalid = 1'b0;
    l = 1;
    while (!s_if.rvalid && l < 20) begin @(negedge ap_clk); l++; end
    d = s_if.rdata; resp = s_if.rresp;
    s_if.rready = 1'b1;
    @(negedge ap_clk);
    s_if.rready = 1'b0;
  endtask

  initial begin
    s_if.awaddr = '0; s_if.awvalid = 1'b0; s_if.wdata = '0; s_if.wstrb = '0;
    s_if.wvalid = 1'b0; s_if.bready = 1'b0; s_if.araddr = '0; s_if.arvalid = 1'b0;
    s_if.rready = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bresp = 2'b00; m_if.bvalid = 1'b0;
    m_if.arready = 1'b0; m_if.rdata = '0; m_if.rresp = 2'b00; m_if.rvalid = 1'b0;

    // Reset state, including requests presented while reset is held
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1; s_if.arvalid = 1'b1;
    repeat (2) @(negedge ap_clk);
    chk("rst_awready", 32'(s_if.awready), 32'd0);
    chk("rst_arready", 32'(s_if.arready), 32'd0);
    chk("rst_bvalid",  32'(s_if.bvalid),  32'd0);
    chk("rst_rvalid",  32'(s_if.rvalid),  32'd0);
    chk("rst_m_valids", 32'({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready}), 32'd0);
    chk("rst_intr", 32'(interrupt), 32'd0);
    chk("rst_ctx",  32'(interrupt_ctx), 32'd0);
    chk("intr_src", 32'(interrupt_src), 32'd0);
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
    ap_rst = 1'b0;

    // Read-only identity registers
    host_read(32'h10, rd, rsp, lat);
    chk("type_data", rd, 32'h00000006);
    chk("type_resp", 32'(rsp), 32'd0);
    chk("type_lat",  32'(lat), 32'd2);
    host_read(32'h14, rd, rsp, lat);
    chk("ver_data", rd, 32'h00000000);

    // Context register and ignored write to a read-only register
    host_write(32'h08, 32'h000000A5, rsp, lat);
    chk("ctx_bresp", 32'(rsp), 32'd0);
    chk("ctx_wlat",  32'(lat), 32'd2);
    chk("ctx_out",   32'(interrupt_ctx), 32'hA5);
    host_read(32'h08, rd, rsp, lat);
    chk("ctx_read", rd, 32'h000000A5);
    host_write(32'h10, 32'h12345678, rsp, lat);
    host_read(32'h10, rd, rsp, lat);
    chk("ro_type_kept", rd, 32'h00000006);
    host_read(32'h40, rd, rsp, lat);
    chk("unmapped_rd", rd, 32'h0);

    // Forwarded write: AW ready after 3 cycles, W ready at once, SLVERR back
    @(negedge ap_clk);
    s_if.awaddr = 32'h1004; s_if.awvalid = 1'b1;
    s_if.wdata = 32'hDEADBEEF; s_if.wstrb = 4'hF; s_if.wvalid = 1'b1;
    m_if.wready = 1'b1;
    #1 chk("fw_accept", 32'(s_if.awready), 32'd1);
    @(negedge ap_clk);
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    chk("fw_awvalid1", 32'(m_if.awvalid), 32'd1);
    chk("fw_wvalid1",  32'(m_if.wvalid),  32'd1);
    chk("fw_awaddr",   m_if.awaddr, 32'h00000F04);
    chk("fw_wdata",    m_if.wdata,  32'hDEADBEEF);
    chk("fw_wstrb",    32'(m_if.wstrb), 32'hF);
    @(negedge ap_clk);
    chk("fw_wvalid2",  32'(m_if.wvalid),  32'd0);
    chk("fw_awvalid2", 32'(m_if.awvalid), 32'd1);
    @(negedge ap_clk);
    chk("fw_awvalid3", 32'(m_if.awvalid), 32'd1);
    @(negedge ap_clk);
    chk("fw_awvalid4", 32'(m_if.awvalid), 32'd1);
    m_if.awready = 1'b1;
    @(negedge ap_clk);
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    chk("fw_awvalid5", 32'(m_if.awvalid), 32'd0);
    chk("fw_bready",   32'(m_if.bready),  32'd1);
    chk("fw_no_bvalid", 32'(s_if.bvalid), 32'd0);
    m_if.bvalid = 1'b1; m_if.bresp = 2'b10;
    @(negedge ap_clk);
    m_if.bvalid = 1'b0; m_if.bresp = 2'b00;
    chk("fw_s_bvalid", 32'(s_if.bvalid), 32'd1);
    chk("fw_s_bresp",  32'(s_if.bresp),  32'd2);
    s_if.bready = 1'b1;
    @(negedge ap_clk);
    s_if.bready = 1'b0;
    chk("fw_done", 32'(s_if.bvalid), 32'd0);

    // Forwarded read with EXOKAY response
    @(negedge ap_clk);
    s_if.araddr = 32'h2000; s_if.arvalid = 1'b1;
    #1 chk("fr_accept", 32'(s_if.arready), 32'd1);
    @(negedge ap_clk);
    s_if.arvalid = 1'b0;
    chk("fr_arvalid", 32'(m_if.arvalid), 32'd1);
    chk("fr_araddr",  m_if.araddr, 32'h00001F00);
    m_if.arready = 1'b1;
    @(negedge ap_clk);
    m_if.arready = 1'b0;
    chk("fr_arvalid_off", 32'(m_if.arvalid), 32'd0);
    chk("fr_rready", 32'(m_if.rready), 32'd1);
    m_if.rvalid = 1'b1; m_if.rdata = 32'h12345678; m_if.rresp = 2'b01;
    @(negedge ap_clk);
    m_if.rvalid = 1'b0;
    chk("fr_s_rvalid", 32'(s_if.rvalid), 32'd1);
    chk("fr_s_rdata",  s_if.rdata, 32'h12345678);
    chk("fr_s_rresp",  32'(s_if.rresp), 32'd1);
    s_if.rready = 1'b1;
    @(negedge ap_clk);
    s_if.rready = 1'b0;

    // Write and read presented together: write first, read after bready
    @(negedge ap_clk);
    s_if.awaddr = 32'h04; s_if.awvalid = 1'b1; s_if.wdata = 32'h1; s_if.wvalid = 1'b1;
    s_if.araddr = 32'h00; s_if.arvalid = 1'b1;
    #1;
    chk("tie_awready", 32'(s_if.awready), 32'd1);
    chk("tie_arready", 32'(s_if.arready), 32'd0);
    @(negedge ap_clk);
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    chk("tie_arready_lwr", 32'(s_if.arready), 32'd0);
    @(negedge ap_clk);
    chk("tie_bvalid", 32'(s_if.bvalid), 32'd1);
    chk("tie_arready_sb", 32'(s_if.arready), 32'd0);
    s_if.bready = 1'b1;
    @(negedge ap_clk);
    s_if.bready = 1'b0;
    #1 chk("tie_rd_accept", 32'(s_if.arready), 32'd1);
    @(negedge ap_clk);
    s_if.arvalid = 1'b0;
    @(negedge ap_clk);
    chk("tie_rvalid", 32'(s_if.rvalid), 32'd1);
    chk("tie_status", s_if.rdata, 32'h00000002);
    s_if.rready = 1'b1;
    @(negedge ap_clk);
    s_if.rready = 1'b0;

    // Interrupt raise, hold, ack
    nvdla_intr = 1'b1;
    @(negedge ap_clk);
    @(negedge ap_clk);
    chk("irq_raise", 32'(interrupt), 32'd1);
    @(negedge ap_clk);
    chk("irq_hold", 32'(interrupt), 32'd1);
    interrupt_ack = 1'b1;
    @(negedge ap_clk);
    interrupt_ack = 1'b0;
    chk("irq_ack", 32'(interrupt), 32'd0);
    // Second edge coincident with ack
    nvdla_intr = 1'b0;
    repeat (2) @(negedge ap_clk);
    nvdla_intr = 1'b1;
    @(negedge ap_clk);
    interrupt_ack = 1'b1;
    @(negedge ap_clk);
    interrupt_ack = 1'b0;
    chk("irq_edge_beats_ack", 32'(interrupt), 32'd1);
    // Disabling does not clear pending
    host_write(32'h04, 32'h0, rsp, lat);
    chk("irq_dis_keeps", 32'(interrupt), 32'd1);
    host_read(32'h00, rd, rsp, lat);
    chk("status_pend_only", rd, 32'h00000001);
    @(negedge ap_clk);
    interrupt_ack = 1'b1;
    @(negedge ap_clk);
    interrupt_ack = 1'b0;
    chk("irq_ack2", 32'(interrupt), 32'd0);
    // Edge while disabled is dropped
    nvdla_intr = 1'b0;
    repeat (2) @(negedge ap_clk);
    nvdla_intr = 1'b1;
    repeat (3) @(negedge ap_clk);
    chk("irq_disabled_drop", 32'(interrupt), 32'd0);

    // Re-arm interrupt, then reset during a forwarded read in F_RD_R
    host_write(32'h04, 32'h1, rsp, lat);
    chk("irq_no_late", 32'(interrupt), 32'd0);
    nvdla_intr = 1'b0;
    repeat (2) @(negedge ap_clk);
    nvdla_intr = 1'b1;
    repeat (2) @(negedge ap_clk);
    chk("irq_rearm", 32'(interrupt), 32'd1);
    @(negedge ap_clk);
    s_if.araddr = 32'h1200; s_if.arvalid = 1'b1;
    @(negedge ap_clk);
    s_if.arvalid = 1'b0;
    chk("rr_araddr", m_if.araddr, 32'h00001100);
    m_if.arready = 1'b1;
    @(negedge ap_clk);
    m_if.arready = 1'b0;
    chk("rr_in_frdr", 32'(m_if.rready), 32'd1);
    m_if.rvalid = 1'b1; m_if.rdata = 32'hCAFEF00D; m_if.rresp = 2'b00;
    ap_rst = 1'b1;
    #1;
    chk("rr_rready",  32'(m_if.rready), 32'd0);
    chk("rr_srvalid", 32'(s_if.rvalid), 32'd0);
    chk("rr_intr",    32'(interrupt),   32'd0);
    chk("rr_ctx",     32'(interrupt_ctx), 32'd0);
    @(negedge ap_clk);
    m_if.rvalid = 1'b0;
    ap_rst = 1'b0;
    repeat (2) @(negedge ap_clk);
    chk("rr_no_resp", 32'({s_if.rvalid, s_if.bvalid}), 32'd0);
    host_read(32'h10, rd, rsp, lat);
    chk("rr_after_data", rd, 32'h00000006);
    chk("rr_after_lat",  32'(lat), 32'd2);
    host_read(32'h00, rd, rsp, lat);
    chk("rr_status_clr", rd, 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
